// File: rtl/spectrum_bank_ctrl_pkg.sv
// Shared definitions for the spectrum RAM path: controller state encoding and
// the default bin index / magnitude widths used by the RAM and renderer.
package spectrum_bank_ctrl_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   typedef enum logic {
      FILL  = 1'b0,
      READY = 1'b1
   } bank_state_t;

   function automatic logic [7:0] satInc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/spectrum_bank_ctrl_if.sv
// Bin stream from the FFT magnitude path plus the spectrum RAM write port.
// The controller is the slave of the stream and drives the RAM write side.
interface spectrum_bank_ctrl_if
   import spectrum_bank_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              mem_we;
   logic [ADDR_W:0]   mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, mem_we, mem_waddr, mem_wdata
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, mem_we, mem_waddr, mem_wdata
   );
endinterface

// File: rtl/spectrum_bank_ctrl_vsync_edge_det.sv
// Registers active-low vsync and emits a one-cycle pulse at the start of the
// sync pulse; resetting the register high suppresses a false edge after reset.
module vsync_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic vsync_i,
   output logic fall_o
);
   logic vsync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vsync_q <= 1'b1;
      end else begin
         vsync_q <= vsync_i;
      end
   end

   assign fall_o = vsync_q & ~vsync_i;
endmodule

// File: rtl/spectrum_bank_ctrl.sv
// Ping-pong bank controller: fills the back bank from the bin stream and swaps
// banks only at the start of vsync so the renderer never sees a torn spectrum.
module spectrum_bank_ctrl
   import spectrum_bank_ctrl_pkg::*;
#(
   parameter int NUM_BINS       = 256,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_FRAMES = 4
) (
   input  logic                clk_pixel,
   input  logic                rst_n,
   input  logic                vsync,
   spectrum_bank_ctrl_if.slave bus,
   input  logic [ADDR_W-1:0]   rd_bin,
   output logic [ADDR_W:0]     rd_addr,
   output logic                front_bank,
   output logic                swap_pulse,
   output logic [7:0]          frame_err_cnt,
   output logic                err_timeout
);
   localparam int TMO_W = (TIMEOUT_FRAMES < 2) ? 1 : $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BINS - 1);
   localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(TIMEOUT_FRAMES - 1);

   bank_state_t       state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              front_q, front_d;
   logic [7:0]        errCnt_q, errCnt_d;
   logic              errTmo_q, errTmo_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              vsEvt;
   logic              xfer;

   vsync_edge_det uVsyncEdge (
      .clk_i   (clk_pixel),
      .rst_ni  (rst_n),
      .vsync_i (vsync),
      .fall_o  (vsEvt)
   );

   assign bus.s_ready   = (state_q == FILL);
   assign xfer          = bus.s_valid & bus.s_ready;
   assign bus.mem_we    = xfer;
   assign bus.mem_waddr = {~front_q, idx_q};
   assign bus.mem_wdata = bus.s_data;
   assign rd_addr       = {front_q, rd_bin};
   assign front_bank    = front_q;
   assign frame_err_cnt = errCnt_q;
   assign err_timeout   = errTmo_q;

   always_ff @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         idx_q    <= '0;
         front_q  <= 1'b0;
         errCnt_q <= '0;
         errTmo_q <= 1'b0;
         tmo_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         front_q  <= front_d;
         errCnt_q <= errCnt_d;
         errTmo_q <= errTmo_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      front_d    = front_q;
      errCnt_d   = errCnt_q;
      errTmo_d   = errTmo_q;
      tmo_d      = tmo_q;
      swap_pulse = 1'b0;
      case (state_q)
         FILL: begin
            // A full bin count completes the frame regardless of s_last.
            if (xfer) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = READY;
               end else if (bus.s_last) begin
                  idx_d    = '0;
                  errCnt_d = satInc8(errCnt_q);
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
            // Abandoning a stale fill overrides the index advance of a same-cycle write.
            if (vsEvt && (idx_q != '0)) begin
               if (tmo_q == TMO_LIMIT) begin
                  idx_d    = '0;
                  errTmo_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            if ((idx_d == '0) || (state_d != FILL)) begin
               tmo_d = '0;
            end
         end
         READY: begin
            if (vsEvt) begin
               front_d    = ~front_q;
               swap_pulse = 1'b1;
               state_d    = FILL;
               idx_d      = '0;
            end
         end
         default: state_d = FILL;
      endcase
   end
endmodule

// File: tb/tb_spectrum_bank_ctrl.sv
// Directed bench for the spectrum bank controller: a frame-level model predicts
// every output each cycle, and hand-computed literals pin key scenarios.
module tb_spectrum_bank_ctrl;
   localparam int NB  = 8;
   localparam int TMO = 2;
   localparam int AW  = 8;
   localparam int DW  = 16;

   typedef struct {
      bit filling;
      int idx;
      bit front;
      int errCnt;
      bit tmoFlag;
      int vsyncCount;
      bit prevVs;
   } model_t;

   logic          clk_pixel = 1'b0;
   logic          rst_n = 1'b1;
   logic          vsync = 1'b1;
   logic [AW-1:0] rd_bin = '0;
   logic [AW:0]   rd_addr;
   logic          front_bank;
   logic          swap_pulse;
   logic [7:0]    frame_err_cnt;
   logic          err_timeout;

   int checks = 0;
   int errors = 0;
   int logAddr[$];
   int logData[$];
   logic sw;
   model_t mdl;

   spectrum_bank_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   spectrum_bank_ctrl #(
      .NUM_BINS(NB), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_FRAMES(TMO)
   ) dut (
      .clk_pixel     (clk_pixel),
      .rst_n         (rst_n),
      .vsync         (vsync),
      .bus           (bus),
      .rd_bin        (rd_bin),
      .rd_addr       (rd_addr),
      .front_bank    (front_bank),
      .swap_pulse    (swap_pulse),
      .frame_err_cnt (frame_err_cnt),
      .err_timeout   (err_timeout)
   );

   always #5 clk_pixel = ~clk_pixel;

   // Frame-level model: a fill accepts bins until NUM_BINS arrive, a display swap
   // waits for a vsync start, stale partial fills expire after TMO vsync starts.
   function automatic model_t resetModel();
      model_t m;
      m.filling = 1'b1;
      m.idx = 0;
      m.front = 1'b0;
      m.errCnt = 0;
      m.tmoFlag = 1'b0;
      m.vsyncCount = 0;
      m.prevVs = 1'b1;
      return m;
   endfunction

   function automatic model_t stepModel(model_t m, bit vs, bit valid, bit last);
      model_t n = m;
      bit syncStart = m.prevVs && !vs;
      n.prevVs = vs;
      if (m.filling) begin
         if (valid) begin
            if (m.idx == NB - 1) begin
               n.idx = 0;
               n.filling = 1'b0;
            end else if (last) begin
               n.idx = 0;
               if (m.errCnt < 255) n.errCnt = m.errCnt + 1;
            end else begin
               n.idx = m.idx + 1;
            end
         end
         if (syncStart && m.idx != 0) begin
            n.vsyncCount = m.vsyncCount + 1;
            if (n.vsyncCount >= TMO) begin
               n.idx = 0;
               n.tmoFlag = 1'b1;
            end
         end
         if (n.idx == 0 || !n.filling) n.vsyncCount = 0;
      end else if (syncStart) begin
         n.front = !m.front;
         n.filling = 1'b1;
         n.idx = 0;
      end
      return n;
   endfunction

   always @(posedge clk_pixel or negedge rst_n) begin
      if (!rst_n) mdl <= resetModel();
      else        mdl <= stepModel(mdl, vsync, bus.s_valid, bus.s_last);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s actual 0x%0h required 0x%0h at %0t", name, act, want, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled mid-cycle on the falling edge.
   always @(negedge clk_pixel) begin
      if (rst_n) begin
         automatic bit expWe = bus.s_valid && mdl.filling;
         automatic bit expSwap = !mdl.filling && mdl.prevVs && !vsync;
         checkOutput("s_ready", 32'(bus.s_ready), 32'(mdl.filling));
         checkOutput("mem_we", 32'(bus.mem_we), 32'(expWe));
         if (expWe) begin
            checkOutput("mem_waddr", 32'(bus.mem_waddr), 32'((int'(!mdl.front) << AW) + mdl.idx));
            checkOutput("mem_wdata", 32'(bus.mem_wdata), 32'(bus.s_data));
         end
         checkOutput("front_bank", 32'(front_bank), 32'(mdl.front));
         checkOutput("swap_pulse", 32'(swap_pulse), 32'(expSwap));
         checkOutput("rd_addr", 32'(rd_addr), 32'((int'(mdl.front) << AW) + int'(rd_bin)));
         checkOutput("frame_err_cnt", 32'(frame_err_cnt), 32'(mdl.errCnt));
         checkOutput("err_timeout", 32'(err_timeout), 32'(mdl.tmoFlag));
         if (bus.mem_we) begin
            logAddr.push_back(int'(bus.mem_waddr));
            logData.push_back(int'(bus.mem_wdata));
         end
      end
   end

   task automatic setInputs(input bit v, input int d, input bit l, input bit vs);
      bus.s_valid = v;
      bus.s_data  = DW'(d);
      bus.s_last  = l;
      vsync       = vs;
      rd_bin      = AW'($urandom_range(0, 255));
   endtask

   task automatic tick();
      @(posedge clk_pixel);
      #1;
   endtask

   task automatic applyStimulus(input bit v, input int d, input bit l, input bit vs);
      setInputs(v, d, l, vs);
      tick();
   endtask

   // Three low cycles then two high; reports swap_pulse seen in the first low cycle.
   task automatic vsyncPulse(output logic swapSeen);
      setInputs(1'b0, 0, 1'b0, 1'b0);
      #2;
      swapSeen = swap_pulse;
      tick();
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic sendFrame(input int base, input int count, input int lastAt);
      for (int i = 0; i < count; i++) applyStimulus(1'b1, base + i, i == lastAt, 1'b1);
      setInputs(1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic clearLog();
      logAddr.delete();
      logData.delete();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual running required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      #1 rst_n = 1'b0;
      #6;
      checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
      checkOutput("rst_front", 32'(front_bank), 32'd0);
      checkOutput("rst_swap", 32'(swap_pulse), 32'd0);
      checkOutput("rst_errcnt", 32'(frame_err_cnt), 32'd0);
      checkOutput("rst_tmo", 32'(err_timeout), 32'd0);
      tick();
      rst_n = 1'b1;
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);

      // First frame lands in bank 1, then the swap makes bank 1 visible.
      clearLog();
      sendFrame('h10, 8, 7);
      checkOutput("t1_count", 32'(logAddr.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         checkOutput("t1_waddr", 32'(logAddr[i]), 32'('h100 + i));
         checkOutput("t1_wdata", 32'(logData[i]), 32'('h10 + i));
      end
      checkOutput("t1_ready_low", 32'(bus.s_ready), 32'd0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      vsyncPulse(sw);
      checkOutput("t1_swap", 32'(sw), 32'd1);
      checkOutput("t1_front", 32'(front_bank), 32'd1);
      rd_bin = 8'd3;
      #1;
      checkOutput("t1_rd_addr", 32'(rd_addr), 32'h103);

      // Second frame goes to bank 0; READY ignores s_valid until the next sync start.
      clearLog();
      sendFrame('h20, 8, 7);
      for (int i = 0; i < 8; i++) checkOutput("t2_waddr", 32'(logAddr[i]), 32'(i));
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 'h99, 1'b0, 1'b1);
      checkOutput("t2_hold_count", 32'(logAddr.size()), 32'd8);
      checkOutput("t2_front_hold", 32'(front_bank), 32'd1);
      setInputs(1'b1, 'h30, 1'b0, 1'b0);
      #2;
      checkOutput("t2_we_on_swap", 32'(bus.mem_we), 32'd0);
      checkOutput("t2_swap", 32'(swap_pulse), 32'd1);
      tick();
      for (int i = 0; i < 8; i++) applyStimulus(1'b1, 'h30 + i, i == 7, i >= 2);
      setInputs(1'b0, 0, 1'b0, 1'b1);
      checkOutput("t2_first_addr", 32'(logAddr[8]), 32'h100);
      checkOutput("t2_first_data", 32'(logData[8]), 32'h30);
      vsyncPulse(sw);

      // Short frame is counted and discarded; a full frame then completes.
      clearLog();
      sendFrame('h40, 5, 4);
      checkOutput("t3_errcnt", 32'(frame_err_cnt), 32'd1);
      sendFrame('h50, 8, 7);
      checkOutput("t3_count", 32'(logAddr.size()), 32'd13);
      checkOutput("t3_restart_addr", 32'(logAddr[5]), 32'h000);
      checkOutput("t3_last_addr", 32'(logAddr[12]), 32'h007);
      checkOutput("t3_front", 32'(front_bank), 32'd1);
      vsyncPulse(sw);

      // Partial fill abandoned after two sync starts; flag stays set afterwards.
      clearLog();
      sendFrame('h60, 3, -1);
      vsyncPulse(sw);
      checkOutput("t4_tmo_early", 32'(err_timeout), 32'd0);
      vsyncPulse(sw);
      checkOutput("t4_tmo", 32'(err_timeout), 32'd1);
      sendFrame('h70, 8, 7);
      checkOutput("t4_restart_addr", 32'(logAddr[3]), 32'h100);
      vsyncPulse(sw);
      checkOutput("t4_swap", 32'(sw), 32'd1);
      checkOutput("t4_tmo_sticky", 32'(err_timeout), 32'd1);

      // Final bin coincides with sync start: no swap until the next one.
      sendFrame('h80, 7, -1);
      setInputs(1'b1, 'h87, 1'b1, 1'b0);
      #2;
      checkOutput("t5_we", 32'(bus.mem_we), 32'd1);
      checkOutput("t5_no_swap", 32'(swap_pulse), 32'd0);
      tick();
      checkOutput("t5_ready_low", 32'(bus.s_ready), 32'd0);
      checkOutput("t5_front", 32'(front_bank), 32'd1);
      applyStimulus(1'b0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      applyStimulus(1'b0, 0, 1'b0, 1'b1);
      vsyncPulse(sw);
      checkOutput("t5_swap", 32'(sw), 32'd1);
      checkOutput("t5_front_after", 32'(front_bank), 32'd0);

      // Reset mid-fill with bank 1 displayed.
      sendFrame('h90, 8, 7);
      vsyncPulse(sw);
      sendFrame('hA0, 4, -1);
      checkOutput("t6_front_pre", 32'(front_bank), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_front", 32'(front_bank), 32'd0);
      checkOutput("t6_ready", 32'(bus.s_ready), 32'd1);
      checkOutput("t6_errcnt", 32'(frame_err_cnt), 32'd0);
      checkOutput("t6_tmo", 32'(err_timeout), 32'd0);
      tick();
      rst_n = 1'b1;
      clearLog();
      applyStimulus(1'b1, 'hB0, 1'b0, 1'b1);
      setInputs(1'b0, 0, 1'b0, 1'b1);
      checkOutput("t6_first_addr", 32'(logAddr[0]), 32'h100);
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spectrum_bank_ctrl.md
Name: spectrum_bank_ctrl

Overview:
Ping-pong bank controller for the spectrum RAM that sits between the FFT magnitude stream and the display renderer.
- Accepts one frame of NUM_BINS bin values over a valid/ready stream and writes it into the back bank.
- Swaps front/back banks only on the start of the vertical sync pulse, so the renderer never sees a partially written spectrum.
- Runs entirely in the pixel clock domain. It consumes the active-low vsync from the video timing generator and maps renderer bin indices to physical RAM addresses.

Parameters:
NUM_BINS, 256, bins per spectrum frame; must be ≤ 2**ADDR_W
ADDR_W, 8, bin index width
DATA_W, 16, bin magnitude width
TIMEOUT_FRAMES, 4, vsync events a partial fill may span before it is abandoned

Ports:
clk_pixel  in  1  pixel clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
vsync  in  1  active-low vertical sync from video timing
s_valid  in  1  bin data valid
s_ready  out  1  controller accepts bin
s_data  in  DATA_W  bin magnitude
s_last  in  1  marks final bin of a spectrum frame
mem_we  out  1  spectrum RAM write enable
mem_waddr  out  ADDR_W+1  {bank, bin index}
mem_wdata  out  DATA_W  write data
rd_bin  in  ADDR_W  bin index requested by renderer
rd_addr  out  ADDR_W+1  {front_bank, rd_bin}, combinational
front_bank  out  1  bank currently displayed
swap_pulse  out  1  one-cycle pulse on bank swap
frame_err_cnt  out  8  saturating count of short frames (early s_last)
err_timeout  out  1  sticky: a partial fill timed out

Behaviour:
- Reset values: state FILL, idx 0, front_bank 0, swap_pulse 0, frame_err_cnt 0, err_timeout 0, vsync_q 1, tmo_cnt 0.
- Reset mid-fill discards the partial frame; reset is async on assert and takes effect immediately.
- Vsync event: vs_evt = vsync_q & ~vsync, where vsync_q is vsync registered once. The event is one cycle wide and occurs at the start of the sync pulse (inside blanking). With vsync_q reset to 1, no spurious event follows reset.
- Transfer: xfer = s_valid & s_ready. mem_we = xfer, mem_waddr = {~front_bank, idx}, mem_wdata = s_data, all combinational (zero latency).
- s_ready = 1 in FILL, 0 in READY.
- FILL state:
  - On xfer with idx == NUM_BINS-1: idx←0 and go to READY, whether or not s_last is set.
  - On xfer with s_last and idx < NUM_BINS-1 (short frame): the data is written but the frame is discarded. idx←0, frame_err_cnt increments (saturates at 255), stay in FILL.
  - Any other xfer: idx←idx+1.
  - Timeout: while idx ≠ 0, each vs_evt increments tmo_cnt. When tmo_cnt reaches TIMEOUT_FRAMES: idx←0, tmo_cnt←0, err_timeout←1.
  - tmo_cnt clears whenever idx returns to 0 or the state leaves FILL.
- READY state:
  - Holds until vs_evt.
  - On vs_evt: front_bank toggles, swap_pulse=1 for that cycle, go to FILL with idx 0.
- Simultaneous events:
  - Final-bin xfer and vs_evt in the same cycle: the fill completes and READY is entered, but no swap happens. The swap waits for the next vs_evt, so each frame is displayed for at least one full frame time.
  - vs_evt in READY and s_valid in the same cycle: no xfer (s_ready=0). The first write to the new back bank happens on the following cycle.
- Timeout counting takes priority over idx increment when vs_evt and xfer coincide: the xfer is written, but idx still clears.
- rd_addr follows front_bank immediately after the swap edge. The renderer sees the new bank from the first cycle after swap_pulse.

Decomposition:
- Shared package: state encoding (FILL, READY), and ADDR_W/DATA_W defaults shared with the spectrum RAM and renderer.
- Sub-module: vsync_edge_det (register plus falling-edge pulse). It is reusable by the renderer and other frame-synchronous blocks.
- RAM stays outside this block.

Test Plan (NUM_BINS=8, TIMEOUT_FRAMES=2 unless noted):
- Reset release, stream 8 bins 0x10..0x17 with s_last on the 8th → mem_waddr 0x100..0x107 (bank1), s_ready drops after bin 8; next vsync fall → swap_pulse 1 cycle, front_bank=1, rd_bin=3 gives rd_addr=0x103.
- Second frame 0x20..0x27 after the swap → writes to 0x000..0x007; no swap until the following vsync fall; s_valid held high in READY produces no mem_we.
- s_last on bin 5 → frame_err_cnt=1, idx restarts; a full 8-bin frame then completes normally; front_bank unchanged until vsync.
- 3 bins written, then two vsync falls with no data → err_timeout=1, next bin written to index 0; err_timeout stays 1 through later good frames until reset.
- Final-bin xfer in the same cycle as the vsync fall → no swap_pulse that cycle; swap on the next vsync fall only.
- Assert rst_n low mid-fill (idx=4, front_bank=1) → immediately front_bank=0, s_ready=1, counts cleared, no vs_evt on the first cycle after release.
